// File: rtl/fpmul_ctrl_pkg.sv
// Shared types and constants for the floating-point multiplier front-end controller.
package fpmul_ctrl_pkg;
    localparam int FP_WIDTH = 32;
    localparam logic [FP_WIDTH-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT,
        S_RESP
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fpmul_ctrl_if.sv
// Requester-side bus: N operand pairs in, one-hot grant and response strobes out.
interface fpmul_ctrl_if #(parameter int N = 2);
    import fpmul_ctrl_pkg::*;

    logic [N-1:0]          req_valid;
    logic [N*FP_WIDTH-1:0] req_a;
    logic [N*FP_WIDTH-1:0] req_b;
    logic [N-1:0]          req_ready;
    logic [N-1:0]          rsp_valid;
    logic [FP_WIDTH-1:0]   rsp_product;
    logic                  rsp_error;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_product, rsp_error
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_product, rsp_error
    );
endinterface

// File: rtl/fpmul_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, searching cyclically.
module fpmul_rr_arbiter
    import fpmul_ctrl_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);
    int idx;

    // Descending scan: the candidate closest to ptr is assigned last and wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
            end
        end
    end
endmodule

// File: rtl/fpmul_ctrl.sv
// Shares one fpmultiplier among N requesters: arbitrate, serialise A then B, await ready rise or timeout.
// INIT first ready rise | IDLE arbitrate | LOAD_A/LOAD_B drive operand | WAIT product or timeout | RESP strobe
module fpmul_ctrl
    import fpmul_ctrl_pkg::*;
#(
    parameter int N       = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                clock,
    input  logic                reset,
    fpmul_ctrl_if.slave         bus,
    output logic                busy,
    output logic                mul_nreset,
    output logic [FP_WIDTH-1:0] mul_a,
    input  logic [FP_WIDTH-1:0] mul_product,
    input  logic                mul_ready
);
    localparam int PW = idx_width(N);
    localparam int TW = idx_width(TIMEOUT);

    state_t              state, state_nxt;
    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       g_idx;
    logic [TW-1:0]       timer;
    logic                ready_q;
    logic                rise;
    logic [FP_WIDTH-1:0] op_b;
    logic [FP_WIDTH-1:0] rsp_product_q;
    logic                rsp_error_q;
    logic [N-1:0]        grant;
    logic [PW-1:0]       grant_idx;
    logic                do_grant;
    logic                do_ok;
    logic                do_tmo;

    fpmul_rr_arbiter #(.N(N), .PW(PW)) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign rise = mul_ready & ~ready_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        do_ok     = 1'b0;
        do_tmo    = 1'b0;
        case (state)
            S_INIT:   if (rise) state_nxt = S_IDLE;
            S_IDLE: begin
                if (|bus.req_valid) begin
                    do_grant  = 1'b1;
                    state_nxt = S_LOAD_A;
                end
            end
            S_LOAD_A: state_nxt = S_LOAD_B;
            S_LOAD_B: state_nxt = S_WAIT;
            S_WAIT: begin
                // A rise in the same cycle as the terminal count still delivers the product.
                if (rise) begin
                    do_ok     = 1'b1;
                    state_nxt = S_RESP;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    do_tmo    = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready_q       <= 1'b0;
            rr_ptr        <= '0;
            g_idx         <= '0;
            timer         <= '0;
            op_b          <= '0;
            mul_a         <= '0;
            rsp_product_q <= '0;
            rsp_error_q   <= 1'b0;
        end else begin
            ready_q <= mul_ready;
            if (do_grant) begin
                g_idx  <= grant_idx;
                mul_a  <= bus.req_a[grant_idx*FP_WIDTH +: FP_WIDTH];
                op_b   <= bus.req_b[grant_idx*FP_WIDTH +: FP_WIDTH];
                rr_ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
            end
            if (state == S_LOAD_A) mul_a <= op_b;
            if (state == S_LOAD_B) timer <= '0;
            if (state == S_WAIT)   timer <= timer + 1'b1;
            if (do_ok) begin
                rsp_product_q <= mul_product;
                rsp_error_q   <= 1'b0;
            end else if (do_tmo) begin
                rsp_product_q <= QNAN;
                rsp_error_q   <= 1'b1;
            end
        end
    end

    assign bus.req_ready   = do_grant ? grant : '0;
    assign bus.rsp_valid   = (state == S_RESP) ? (N'(1) << g_idx) : '0;
    assign bus.rsp_product = rsp_product_q;
    assign bus.rsp_error   = rsp_error_q;
    assign busy            = (state != S_IDLE);
    assign mul_nreset      = ~reset;
endmodule

// File: tb/tb_fpmul_ctrl.sv
// Randomised and directed bench for fpmul_ctrl against a transaction-level reference model.
`timescale 1ns/1ps
module tb_fpmul_ctrl;
    import fpmul_ctrl_pkg::*;

    localparam int N       = 3;
    localparam int TIMEOUT = 20;

    logic        clock = 1'b0;
    logic        reset;
    logic        busy;
    logic        mul_nreset;
    logic [31:0] mul_a;
    logic [31:0] mul_product;
    logic        mul_ready;

    int checks   = 0;
    int failures = 0;
    int exp_ptr  = 0;

    fpmul_ctrl_if #(.N(N)) bus();

    fpmul_ctrl #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .mul_nreset  (mul_nreset),
        .mul_a       (mul_a),
        .mul_product (mul_product),
        .mul_ready   (mul_ready)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference arbitration: cyclic search from the round-robin pointer.
    function automatic int pick(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++)
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        return 0;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset         = 1'b1;
        bus.req_valid = '0;
        mul_ready     = 1'b0;
        #1;
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_product", bus.rsp_product, 0);
        chk("rst_rsp_error", bus.rsp_error, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_busy", busy, 1);
        chk("rst_mul_nreset", mul_nreset, 0);
        @(negedge clock);
        reset   = 1'b0;
        exp_ptr = 0;
        repeat (2) begin
            @(negedge clock);
            #1;
            chk("init_busy", busy, 1);
            chk("init_nreset", mul_nreset, 1);
            chk("init_no_rsp", bus.rsp_valid, 0);
        end
        mul_ready = 1'b1;
        @(negedge clock);
        #1;
        chk("idle_after_rise", busy, 0);
    endtask

    task automatic run_op(input logic [N-1:0] mask, input logic [31:0] a_in, input logic [31:0] b_in,
                          input logic [31:0] prod, input int lat, input bit inject, input int abort_after);
        int          w;
        int          c;
        int          elat;
        bit          got;
        bit          eerr;
        logic [31:0] ea, eb, ep;
        logic [N-1:0] oh;

        #1;
        chk("idle_no_grant", bus.req_ready, 0);
        chk("idle_busy", busy, 0);
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*32 +: 32] = a_in ^ (32'(i) * 32'h0101_0101);
            bus.req_b[i*32 +: 32] = b_in ^ (32'(i) * 32'h1010_1010);
        end
        bus.req_valid = mask;
        w  = pick(mask, exp_ptr);
        ea = a_in ^ (32'(w) * 32'h0101_0101);
        eb = b_in ^ (32'(w) * 32'h1010_1010);
        oh = '0;
        oh[w] = 1'b1;

        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (bus.req_ready != 0) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
        chk("grant_seen", got, 1);
        if (!got) begin
            bus.req_valid = '0;
            return;
        end
        chk("grant_onehot", bus.req_ready, oh);
        exp_ptr   = (w + 1) % N;
        mul_ready = 1'b0;

        @(negedge clock);
        bus.req_valid = '0;
        mul_ready     = inject;
        #1;
        chk("load_a", mul_a, ea);
        chk("load_a_busy", busy, 1);

        @(negedge clock);
        mul_ready = 1'b0;
        #1;
        chk("load_b", mul_a, eb);

        if (abort_after > 0) begin
            repeat (abort_after) @(negedge clock);
            #1;
            chk("pre_abort_no_rsp", bus.rsp_valid, 0);
            do_reset();
            return;
        end

        if (lat <= TIMEOUT) begin
            elat = 3 + lat;
            ep   = prod;
            eerr = 1'b0;
        end else begin
            elat = 3 + TIMEOUT;
            ep   = QNAN;
            eerr = 1'b1;
        end

        got = 1'b0;
        c   = 3;
        for (int k = 3; k < 3 + TIMEOUT + 8; k++) begin
            @(negedge clock);
            c = k;
            if (k == 2 + lat) begin
                mul_product = prod;
                mul_ready   = 1'b1;
            end
            #1;
            if (bus.rsp_valid != 0) begin
                got = 1'b1;
                break;
            end
            chk("wait_b_held", mul_a, eb);
        end
        chk("rsp_seen", got, 1);
        if (!got) return;
        chk("rsp_latency", c, elat);
        chk("rsp_valid", bus.rsp_valid, oh);
        chk("rsp_product", bus.rsp_product, ep);
        chk("rsp_error", bus.rsp_error, eerr);

        @(negedge clock);
        #1;
        chk("rsp_one_cycle", bus.rsp_valid, 0);
        chk("rsp_hold", bus.rsp_product, ep);
        chk("rsp_err_hold", bus.rsp_error, eerr);
    endtask

    initial begin
        reset         = 1'b1;
        mul_ready     = 1'b0;
        mul_product   = '0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;

        do_reset();

        run_op(3'b001, 32'hBFC0_0000, 32'h3FE0_0000, 32'hC028_0000, 3, 1'b0, 0);

        do_reset();
        run_op(3'b011, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 2, 1'b0, 0);
        run_op(3'b011, 32'h4040_0000, 32'h4080_0000, 32'h4140_0000, 1, 1'b0, 0);
        run_op(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0BAD_F00D, 4, 1'b0, 0);

        run_op(3'b001, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, TIMEOUT + 3, 1'b0, 0);
        run_op(3'b100, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 2, 1'b0, 0);
        run_op(3'b010, 32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 1, 1'b0, 0);
        run_op(3'b111, 32'h4120_0000, 32'h4120_0000, 32'h42C8_0000, TIMEOUT, 1'b0, 0);
        run_op(3'b111, 32'h4120_0000, 32'h4120_0000, 32'h42C8_0000, TIMEOUT + 1, 1'b0, 0);
        run_op(3'b001, 32'h3F00_0000, 32'h4000_0000, 32'h3F80_0000, 5, 1'b1, 0);

        run_op(3'b010, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1111_2222, 4, 1'b0, 3);
        run_op(3'b110, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 2, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            run_op(N'($urandom_range(1, (1 << N) - 1)), $urandom, $urandom, $urandom,
                   int'($urandom_range(1, TIMEOUT + 2)), 1'($urandom_range(0, 1)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
